// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared op/state encodings for the read-modify-write data memory
package dmem_pkg;
   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_STORE = 4'd0,
      OP_ADD   = 4'd1,
      OP_SUB   = 4'd2,
      OP_AND   = 4'd3,
      OP_OR    = 4'd4,
      OP_XOR   = 4'd5,
      OP_SLL   = 4'd6,
      OP_SRL   = 4'd7,
      OP_LOAD  = 4'd8
   } dm_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } dm_state_e;
endpackage

// File: rtl/dmem_rmw_alu.sv
// rtl/dmem_rmw_alu.sv - combinational fetch-and-op datapath: new word and write enable
module dmem_rmw_alu
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] old_data,
   input  logic [DATA_W-1:0] operand,
   output logic [DATA_W-1:0] new_data,
   output logic              we
);
   localparam int SH_W = $clog2(DATA_W);

   logic [SH_W-1:0] shamt;
   assign shamt = operand[SH_W-1:0];

   always_comb begin
      new_data = old_data;
      we       = 1'b1;
      case (op)
         OP_STORE: new_data = operand;
         OP_ADD:   new_data = old_data + operand;
         OP_SUB:   new_data = old_data - operand;
         OP_AND:   new_data = old_data & operand;
         OP_OR:    new_data = old_data | operand;
         OP_XOR:   new_data = old_data ^ operand;
         OP_SLL:   new_data = old_data << shamt;
         OP_SRL:   new_data = old_data >> shamt;
         // LOAD and every reserved encoding read without writing back
         default:  we = 1'b0;
      endcase
   end
endmodule

// File: rtl/data_memory_rmw.sv
// rtl/data_memory_rmw.sv - clocked data memory with atomic fetch-and-op, IDLE->RD->WR sequence
// Optional DMEM_BOUNDS_CHECK_EN flags out-of-range addresses instead of wrapping them.
module data_memory_rmw
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   dm_state_e         state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] old_q, old_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;

   logic [DATA_W-1:0] alu_new;
   logic              alu_we;
   logic              addr_err;

`ifdef DMEM_BOUNDS_CHECK_EN
   assign addr_err = (req_addr >> IDX_W) != '0;
`else
   logic unused_addr;
   assign unused_addr = ^req_addr;
   assign addr_err    = 1'b0;
`endif

   dmem_rmw_alu #(.DATA_W(DATA_W)) u_alu (
      .op       (op_q),
      .old_data (old_q),
      .operand  (data_q),
      .new_data (alu_new),
      .we       (alu_we)
   );

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      idx_d       = idx_q;
      data_d      = data_q;
      err_d       = err_q;
      old_d       = old_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: if (req_valid) begin
            state_d = RD;
            op_d    = req_op;
            idx_d   = req_addr[IDX_W-1:0];
            data_d  = req_data;
            err_d   = addr_err;
         end
         RD: begin
            old_d   = mem[idx_q];
            state_d = WR;
         end
         WR: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = err_q ? '0 : old_q;
            rsp_err_d   = err_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= '0;
         idx_q       <= '0;
         data_q      <= '0;
         err_q       <= 1'b0;
         old_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         err_q       <= err_d;
         old_q       <= old_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Write gated by state_q, so an asynchronous reset during WR drops the write.
   always_ff @(posedge clk) begin
      if (state_q == WR && alu_we && !err_q)
         mem[idx_q] <= alu_new;
   end
endmodule

// File: tb/tb_data_memory_rmw.sv
// tb/tb_data_memory_rmw.sv - randomized self-checking bench for data_memory_rmw (DMEM_BOUNDS_CHECK_EN aware)
module tb_data_memory_rmw;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;

   data_memory_rmw dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [31:0] data;
      bit          known;
      bit          err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_mem [1024];
   bit          model_kn [1024];
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] apply_op(input logic [3:0] op, input logic [31:0] old, input logic [31:0] d);
      case (op)
         4'd0: return d;
         4'd1: return old + d;
         4'd2: return old - d;
         4'd3: return old & d;
         4'd4: return old | d;
         4'd5: return old ^ d;
         4'd6: return old << (d % 32);
         4'd7: return old >> (d % 32);
         default: return old;
      endcase
   endfunction

   // Compare process: every cycle out of reset, rsp_valid must match the schedule.
   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("rsp_missed", 32'd0, 32'd1);
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            if (e.known) chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
         end else begin
            chk("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
         end
      end
   end

   // Called at a negedge; returns the word the model says the op will fetch.
   task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] d,
                        input bit track, output logic [31:0] exp_old);
      int   waitc = 0;
      int   idx;
      bit   err;
      exp_t e;
      while (!req_ready) begin
         @(negedge clk);
         waitc++;
         if (waitc > 20) begin
            chk("ready_timeout", {31'd0, req_ready}, 32'd1);
            exp_old = '0;
            return;
         end
      end
      idx = int'(addr % 1024);
`ifdef DMEM_BOUNDS_CHECK_EN
      err = (addr >= 1024);
`else
      err = 1'b0;
`endif
      e.cyc   = cyc + 3;
      e.err   = err;
      e.data  = err ? 32'd0 : model_mem[idx];
      e.known = err ? 1'b1 : model_kn[idx];
      exp_old = e.data;
      if (track) begin
         exp_q.push_back(e);
         if (!err && op < 4'd8) begin
            model_mem[idx] = apply_op(op, model_mem[idx], d);
            model_kn[idx]  = model_kn[idx] || (op == 4'd0);
         end
      end
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_data  = d;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   logic [31:0] r;
   logic [31:0] pool [8];
   int          accepts;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         model_mem[i] = '0;
         model_kn[i]  = 1'b0;
      end
      rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0;
      repeat (3) @(negedge clk);
      chk("reset_ready", {31'd0, req_ready}, 32'd1);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_rsp_data", rsp_data, 32'd0);
      chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(4'd0, 32'd5, 32'hDEADBEEF, 1, r);
      issue(4'd8, 32'd5, 32'd0, 1, r);       chk("model_load5", r, 32'hDEADBEEF);

      issue(4'd0, 32'd2, 32'd10, 1, r);
      issue(4'd1, 32'd2, -32'sd3, 1, r);     chk("model_add_old", r, 32'd10);
      issue(4'd8, 32'd2, 32'd0, 1, r);       chk("model_add_new", r, 32'd7);
      issue(4'd2, 32'd2, 32'd8, 1, r);       chk("model_sub_old", r, 32'd7);
      issue(4'd8, 32'd2, 32'd0, 1, r);       chk("model_sub_new", r, 32'hFFFFFFFF);

      issue(4'd0, 32'd3, 32'h0000000F, 1, r);
      issue(4'd6, 32'd3, 32'd36, 1, r);
      issue(4'd8, 32'd3, 32'd0, 1, r);       chk("model_sll", r, 32'h000000F0);
      issue(4'd7, 32'd3, 32'd4, 1, r);
      issue(4'd8, 32'd3, 32'd0, 1, r);       chk("model_srl", r, 32'h0000000F);
      issue(4'd5, 32'd3, 32'hFF, 1, r);
      issue(4'd12, 32'd3, 32'h55, 1, r);     chk("model_xor", r, 32'h000000F0);
      issue(4'd8, 32'd3, 32'd0, 1, r);       chk("model_reserved_nowrite", r, 32'h000000F0);
      drain();

      // req_valid held for 9 cycles: accepts only in IDLE, one every third cycle
      accepts = 0;
      for (int i = 0; i < 9; i++) begin
         exp_t e;
         chk("ready_pattern", {31'd0, req_ready}, {31'd0, (i % 3 == 0)});
         if (req_ready) begin
            accepts++;
            e.cyc = cyc + 3; e.data = model_mem[5]; e.known = 1'b1; e.err = 1'b0;
            exp_q.push_back(e);
         end
         req_valid = 1'b1; req_op = 4'd8; req_addr = 32'd5; req_data = '0;
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("hold_accepts", accepts, 32'd3);
      drain();

      // reset during WR drops the pending store and its response
      issue(4'd0, 32'd9, 32'd0, 1, r);
      drain();
      issue(4'd0, 32'd9, 32'd1, 0, r);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset_ready", {31'd0, req_ready}, 32'd1);
      chk("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midreset_rsp_data", rsp_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      issue(4'd8, 32'd9, 32'd0, 1, r);       chk("model_reset_drop", r, 32'd0);
      drain();

      // out-of-range address: error with macro, wrap to index 0 without
      issue(4'd0, 32'd0, 32'h1234, 1, r);
      issue(4'd0, 32'd1024, 32'hABCD, 1, r);
      issue(4'd8, 32'd0, 32'd0, 1, r);
`ifdef DMEM_BOUNDS_CHECK_EN
      chk("model_bounds", r, 32'h1234);
`else
      chk("model_wrap", r, 32'hABCD);
`endif
      drain();

      pool[0] = 32'd5;  pool[1] = 32'd2;    pool[2] = 32'd1023;        pool[3] = 32'd0;
      pool[4] = 32'd17; pool[5] = 32'd1041; pool[6] = 32'd4096 + 1023; pool[7] = 32'd2048;
      for (int i = 0; i < 8; i++) issue(4'd0, pool[i], $urandom, 1, r);
      for (int i = 0; i < 300; i++) begin
         logic [3:0]  op;
         logic [31:0] a;
         logic [31:0] d;
         op = 4'($urandom_range(0, 15));
         a  = pool[$urandom_range(0, 7)];
         d  = $urandom;
         issue(op, a, d, 1, r);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
